// File: rtl/rip_bp_update_ctrl.sv
// Branch-predictor table update controller: clears the counter table after reset
// or clear_req, then drains buffered resolved-branch updates as 2-bit saturating writes.
module rip_bp_update_ctrl #(
    parameter int unsigned TABLE_DEPTH = 10,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter logic [1:0]  INIT_VALUE  = 2'b01
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   clear_req,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [TABLE_DEPTH-1:0] in_index,
    input  logic [1:0]             in_weight,
    input  logic                   in_actual,
    output logic                   tbl_we,
    output logic [TABLE_DEPTH-1:0] tbl_addr,
    output logic [1:0]             tbl_din,
    output logic                   hist_valid,
    output logic                   hist_bit,
    output logic                   init_done
);

    localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned ENTRY_W = TABLE_DEPTH + 3;
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t state;
    state_t next_state;

    logic [TABLE_DEPTH-1:0] sweep_cnt;

    logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W:0]     fifo_count;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;

    logic [ENTRY_W-1:0]     head;
    logic [TABLE_DEPTH-1:0] head_index;
    logic [1:0]             head_weight;
    logic                   head_actual;

    logic                   byp_valid;
    logic [TABLE_DEPTH-1:0] byp_addr;
    logic [1:0]             byp_val;
    logic [1:0]             base_val;
    logic [1:0]             upd_val;

    logic                   nxt_we;
    logic [TABLE_DEPTH-1:0] nxt_addr;
    logic [1:0]             nxt_din;
    logic                   nxt_hv;
    logic                   nxt_hb;

    function automatic logic [1:0] sat_update(input logic [1:0] base, input logic taken);
        logic [1:0] res;
        case (base)
            2'b00:   res = taken ? 2'b01 : 2'b00;
            2'b01:   res = taken ? 2'b10 : 2'b00;
            2'b10:   res = taken ? 2'b11 : 2'b01;
            default: res = taken ? 2'b11 : 2'b10;
        endcase
        return res;
    endfunction

    assign full      = (fifo_count == FULL_COUNT);
    assign empty     = (fifo_count == '0);
    assign in_ready  = !full;
    assign init_done = (state == ST_RUN);

    assign head        = fifo_mem[rd_ptr];
    assign head_index  = head[ENTRY_W-1:3];
    assign head_weight = head[2:1];
    assign head_actual = head[0];

    // The last write to this index may not yet be visible in the weight the
    // predictor read, so the bypass copy takes precedence on an index match.
    always_comb begin
        base_val = head_weight;
        if (byp_valid && (byp_addr == head_index)) begin
            base_val = byp_val;
        end
        upd_val = sat_update(base_val, head_actual);
    end

    // A clear discards the buffer, so an offer coinciding with it is dropped too.
    always_comb begin
        push = in_valid && in_ready && !clear_req;
        pop  = (state == ST_RUN) && !empty && !clear_req;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_INIT;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_INIT: begin
                if (clear_req) begin
                    next_state = ST_INIT;
                end else if (sweep_cnt == '1) begin
                    next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (clear_req) begin
                    next_state = ST_INIT;
                end
            end
            default: next_state = ST_INIT;
        endcase
    end

    always_comb begin
        nxt_we   = 1'b0;
        nxt_addr = tbl_addr;
        nxt_din  = tbl_din;
        nxt_hv   = 1'b0;
        nxt_hb   = hist_bit;
        if (!clear_req) begin
            if (state == ST_INIT) begin
                nxt_we   = 1'b1;
                nxt_addr = sweep_cnt;
                nxt_din  = INIT_VALUE;
            end else if (pop) begin
                nxt_we   = 1'b1;
                nxt_addr = head_index;
                nxt_din  = upd_val;
                nxt_hv   = 1'b1;
                nxt_hb   = head_actual;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tbl_we     <= 1'b0;
            tbl_addr   <= '0;
            tbl_din    <= '0;
            hist_valid <= 1'b0;
            hist_bit   <= 1'b0;
        end else begin
            tbl_we     <= nxt_we;
            tbl_addr   <= nxt_addr;
            tbl_din    <= nxt_din;
            hist_valid <= nxt_hv;
            hist_bit   <= nxt_hb;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sweep_cnt <= '0;
        end else if (clear_req) begin
            sweep_cnt <= '0;
        end else if (state == ST_INIT) begin
            sweep_cnt <= sweep_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {in_index, in_weight, in_actual};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else if (clear_req) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            byp_valid <= 1'b0;
            byp_addr  <= '0;
            byp_val   <= '0;
        end else if (clear_req) begin
            byp_valid <= 1'b0;
        end else if (pop) begin
            byp_valid <= 1'b1;
            byp_addr  <= head_index;
            byp_val   <= upd_val;
        end
    end

endmodule

// File: tb/tb_rip_bp_update_ctrl.sv
// Directed bench for rip_bp_update_ctrl (TABLE_DEPTH=4, FIFO_DEPTH=4): sweep, update
// arithmetic, bypass, buffering during init, clear and asynchronous reset.
module tb_rip_bp_update_ctrl;

    logic       clk = 1'b0;
    logic       rstn;
    logic       clear_req;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_index;
    logic [1:0] in_weight;
    logic       in_actual;
    logic       tbl_we;
    logic [3:0] tbl_addr;
    logic [1:0] tbl_din;
    logic       hist_valid;
    logic       hist_bit;
    logic       init_done;

    int checks = 0;
    int errors = 0;

    int p_idx [5] = '{9, 9, 7, 7, 12};
    int p_w   [5] = '{0, 0, 3, 3, 1};
    int p_act [5] = '{1, 1, 1, 0, 0};

    always #5 clk = ~clk;

    rip_bp_update_ctrl #(
        .TABLE_DEPTH(4),
        .FIFO_DEPTH (4),
        .INIT_VALUE (2'b01)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .clear_req (clear_req),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_index  (in_index),
        .in_weight (in_weight),
        .in_actual (in_actual),
        .tbl_we    (tbl_we),
        .tbl_addr  (tbl_addr),
        .tbl_din   (tbl_din),
        .hist_valid(hist_valid),
        .hist_bit  (hist_bit),
        .init_done (init_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_drive(input int idx, input int w, input int act);
        in_valid  = 1'b1;
        in_index  = 4'(idx);
        in_weight = 2'(w);
        in_actual = 1'(act);
    endtask

    task automatic idle_in();
        in_valid  = 1'b0;
        in_index  = '0;
        in_weight = '0;
        in_actual = 1'b0;
    endtask

    task automatic expect_reset(input string tag);
        check({tag, "_we"},    32'(tbl_we),     0);
        check({tag, "_addr"},  32'(tbl_addr),   0);
        check({tag, "_din"},   32'(tbl_din),    0);
        check({tag, "_hv"},    32'(hist_valid), 0);
        check({tag, "_hb"},    32'(hist_bit),   0);
        check({tag, "_done"},  32'(init_done),  0);
        check({tag, "_ready"}, 32'(in_ready),   1);
    endtask

    task automatic expect_write(input string tag, input int addr, input int din, input int hb);
        check({tag, "_we"},   32'(tbl_we),     1);
        check({tag, "_addr"}, 32'(tbl_addr),   addr);
        check({tag, "_din"},  32'(tbl_din),    din);
        check({tag, "_hv"},   32'(hist_valid), 1);
        check({tag, "_hb"},   32'(hist_bit),   hb);
    endtask

    task automatic expect_quiet(input string tag);
        check({tag, "_we"}, 32'(tbl_we),     0);
        check({tag, "_hv"}, 32'(hist_valid), 0);
    endtask

    task automatic sweep_check(input string tag, input int i);
        string t;
        t = $sformatf("%s_%0d", tag, i);
        check({t, "_we"},   32'(tbl_we),     1);
        check({t, "_addr"}, 32'(tbl_addr),   i);
        check({t, "_din"},  32'(tbl_din),    1);
        check({t, "_hv"},   32'(hist_valid), 0);
        check({t, "_done"}, 32'(init_done),  (i == 15) ? 1 : 0);
    endtask

    initial begin
        // Reset values, asynchronously and while held across edges
        rstn      = 1'b0;
        clear_req = 1'b0;
        idle_in();
        #1;
        expect_reset("rst_async");
        tick();
        tick();
        expect_reset("rst_hold");
        rstn = 1'b1;

        // Initial sweep: 16 writes of 01, then idle in RUN
        for (int i = 0; i < 16; i++) begin
            tick();
            sweep_check("sweep0", i);
        end
        tick();
        expect_quiet("post_sweep0");
        check("post_sweep0_done", 32'(init_done), 1);

        // Single update: idx5 w=10 taken -> 11, one cycle after acceptance
        push_drive(5, 2, 1);
        check("c_ready", 32'(in_ready), 1);
        tick();
        idle_in();
        expect_quiet("c_latency");
        tick();
        expect_write("c_w5", 5, 3, 1);
        tick();
        expect_quiet("c_after");

        // Back-to-back to idx3: second write builds on the first (10 then 11)
        push_drive(3, 1, 1);
        tick();
        push_drive(3, 1, 1);
        tick();
        expect_write("d_first", 3, 2, 1);
        idle_in();
        tick();
        expect_write("d_second", 3, 3, 1);
        tick();
        expect_quiet("d_after");

        // idx5 not-taken twice: bypass (idx3) misses, then hits idx5=00 over w=11
        push_drive(5, 0, 0);
        tick();
        push_drive(5, 3, 0);
        tick();
        expect_write("d_miss", 5, 0, 0);
        idle_in();
        tick();
        expect_write("d_hit", 5, 0, 0);

        // 10 not-taken -> 01
        push_drive(9, 2, 0);
        tick();
        idle_in();
        tick();
        expect_write("d_dec", 9, 1, 0);
        tick();
        expect_quiet("d_idle");

        // Clear in RUN, then buffer five updates during the sweep
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        expect_quiet("e_clear");
        check("e_clear_done", 32'(init_done), 0);
        check("e_clear_ready", 32'(in_ready), 1);
        for (int i = 0; i < 16; i++) begin
            if (i < 5) push_drive(p_idx[i], p_w[i], p_act[i]);
            tick();
            sweep_check("e_sweep", i);
            if (i == 3 || i == 15) check($sformatf("e_full_%0d", i), 32'(in_ready), 0);
        end
        tick();
        expect_write("e_pop1", 9, 1, 1);
        check("e_ready_free", 32'(in_ready), 1);
        tick();
        expect_write("e_pop2", 9, 2, 1);
        idle_in();
        tick();
        expect_write("e_pop3", 7, 3, 1);
        tick();
        expect_write("e_pop4", 7, 2, 0);
        tick();
        expect_write("e_pop5", 12, 0, 0);
        tick();
        expect_quiet("e_drained");

        // Clear in RUN with three buffered entries: they never get written
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i < 3) push_drive(i + 1, 1, 1);
            else idle_in();
            tick();
            sweep_check("f_sweep", i);
        end
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        expect_quiet("f_clear_run");
        check("f_clear_done", 32'(init_done), 0);
        check("f_clear_ready", 32'(in_ready), 1);
        for (int i = 0; i < 16; i++) begin
            tick();
            sweep_check("f_resweep", i);
        end
        tick();
        expect_quiet("f_discarded");

        // Reset mid-sweep at addr 7 with a full buffer
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i < 4) push_drive(i, 2, 1);
            else idle_in();
            tick();
            sweep_check("g_sweep", i);
        end
        check("g_full", 32'(in_ready), 0);
        #2;
        rstn = 1'b0;
        #1;
        expect_reset("g_async");
        tick();
        expect_reset("g_hold");
        rstn = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            sweep_check("g_resweep", i);
        end
        tick();
        expect_quiet("g_abandoned");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
